// File: rtl/led_bank_pkg.sv
// Shared types, seeds and sizing helpers for the IO-board LED bank sequencer.
package led_bank_pkg;

  // Pattern selection, encoded exactly as the mode pins present it
  typedef enum logic [1:0] {
    MODE_COUNT  = 2'd0,
    MODE_CHASE  = 2'd1,
    MODE_ROTATE = 2'd2,
    MODE_STATIC = 2'd3
  } mode_e;

  // Pattern value loaded when a new mode is taken
  localparam int unsigned SEED_COUNT  = 0;
  localparam int unsigned SEED_CHASE  = 1;
  localparam int unsigned SEED_ROTATE = 1;
  localparam int unsigned SEED_STATIC = 0;

  // Chase direction encoding
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Bits needed to count 0..n-1 (at least one bit)
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Seed associated with a mode
  function automatic int unsigned seed_for(input mode_e m);
    case (m)
      MODE_CHASE:  return SEED_CHASE;
      MODE_ROTATE: return SEED_ROTATE;
      MODE_STATIC: return SEED_STATIC;
      default:     return SEED_COUNT;
    endcase
  endfunction

endpackage

// File: rtl/led_step_prescaler.sv
// Divides the board clock down to a one-clock step pulse every DIV clocks.
module led_step_prescaler
  import led_bank_pkg::*;
#(
  parameter int unsigned DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic step
);

  localparam int unsigned CW   = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..DIV-1; the terminal count emits a registered step pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      step <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      step <= 1'b1;
    end else begin
      cnt  <= cnt + CW'(1);
      step <= 1'b0;
    end
  end

endmodule

// File: rtl/led_bank_sequencer.sv
// LED bank driver: stepped patterns masked per bank by DIP switches, with PWM dimming.
module led_bank_sequencer
  import led_bank_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned STEP_HZ  = 12,
  parameter int unsigned BANKS    = 3,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PWM_BITS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                mode,
  input  logic [BANKS*WIDTH-1:0]    dsw,
  input  logic [PWM_BITS-1:0]       brightness,
  input  logic                      freeze,
  output logic [BANKS*WIDTH-1:0]    lb,
  output logic [7:0]                led,
  output logic                      step
);

  localparam int unsigned N   = BANKS * WIDTH;
  localparam int unsigned DIV = CLK_HZ / STEP_HZ;
  localparam int unsigned SW  = cnt_width(DIV);

  logic [1:0]          mode_s1, mode_s2;
  logic [N-1:0]        dsw_s1, dsw_s2;
  logic [PWM_BITS-1:0] bri_s1, bri_s2;
  logic                frz_s1, frz_s2;

  mode_e               mode_q;
  mode_e               mode_new;
  logic [N-1:0]        pattern;
  logic                dir;
  logic [N-1:0]        pat_adv_c;
  logic                dir_adv_c;
  logic [N-1:0]        seed_c;

  logic [PWM_BITS-1:0] pwm_cnt;
  logic                on_c;

  logic                stretch;
  logic [SW-1:0]       hold_cnt;

  // Two-flop synchronisers for every asynchronous board input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_s1 <= '0;
      mode_s2 <= '0;
      dsw_s1  <= '0;
      dsw_s2  <= '0;
      bri_s1  <= '0;
      bri_s2  <= '0;
      frz_s1  <= 1'b0;
      frz_s2  <= 1'b0;
    end else begin
      mode_s1 <= mode;
      mode_s2 <= mode_s1;
      dsw_s1  <= dsw;
      dsw_s2  <= dsw_s1;
      bri_s1  <= brightness;
      bri_s2  <= bri_s1;
      frz_s1  <= freeze;
      frz_s2  <= frz_s1;
    end
  end

  led_step_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (step)
  );

  assign mode_new = mode_e'(mode_s2);
  assign seed_c   = N'(seed_for(mode_new));

  // Next pattern and chase direction for an ordinary advance in the current mode
  always_comb begin
    pat_adv_c = pattern;
    dir_adv_c = dir;
    case (mode_q)
      MODE_COUNT: pat_adv_c = pattern + N'(1);
      MODE_CHASE: begin
        if (dir == DIR_UP) begin
          pat_adv_c = pattern << 1;
          if (pattern[N-2]) dir_adv_c = DIR_DOWN;
        end else begin
          pat_adv_c = pattern >> 1;
          if (pattern[1]) dir_adv_c = DIR_UP;
        end
      end
      MODE_ROTATE: pat_adv_c = {pattern[N-2:0], pattern[N-1]};
      default: ;
    endcase
  end

  // Mode/pattern state: a mode change on a step reseeds instead of advancing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_COUNT;
      pattern <= '0;
      dir     <= DIR_UP;
    end else if (step) begin
      if (mode_new != mode_q) begin
        mode_q  <= mode_new;
        pattern <= seed_c;
        dir     <= DIR_UP;
      end else if (!frz_s2) begin
        pattern <= pat_adv_c;
        dir     <= dir_adv_c;
      end
    end
  end

  // Free-running PWM phase counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  // Full-scale brightness is solid on; otherwise duty = brightness / 2^PWM_BITS
  assign on_c = (bri_s2 == '1) || (pwm_cnt < bri_s2);

  // Step indicator held high for one full step period after each step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stretch  <= 1'b0;
      hold_cnt <= '0;
    end else if (step) begin
      stretch  <= 1'b1;
      hold_cnt <= '0;
    end else if (stretch) begin
      if (hold_cnt == SW'(DIV - 1)) begin
        stretch <= 1'b0;
      end else begin
        hold_cnt <= hold_cnt + SW'(1);
      end
    end
  end

  // Registered LED bank and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lb  <= '0;
      led <= '0;
    end else begin
      lb  <= ((mode_q == MODE_STATIC) ? dsw_s2 : (pattern & dsw_s2)) & {N{on_c}};
      led <= {4'b0000, stretch, dir, mode_q};
    end
  end

endmodule
